// File: rtl/sipo_pkg.sv
// Shared constants, state encoding and helpers for the sipo deserializer.
// Optional feature macro: SIPO_DROP_CNT_EN (dropped-symbol counter).
package sipo_pkg;

  localparam int unsigned SYM_W         = 2;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned SYMS_PER_WORD = WORD_W / SYM_W;
  localparam int unsigned CNT_W         = $clog2(SYMS_PER_WORD + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } acc_state_e;

  // Left-align a word that holds n symbols by shifting zeros into the unused low slots.
  function automatic logic [WORD_W-1:0] left_align(input logic [WORD_W-1:0] acc,
                                                   input logic [CNT_W-1:0]  n);
    int unsigned shamt;
    shamt = SYM_W * (SYMS_PER_WORD - int'(n));
    return acc << shamt;
  endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// Single-entry output register with valid/ready handshake; data and partial flag
// are held stable while the consumer stalls.
module sipo_out_slot
  import sipo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_partial,
  input  logic              i_ready,
  output logic              o_free,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data,
  output logic              o_partial
);

  logic              r_valid;
  logic [WORD_W-1:0] r_data;
  logic              r_partial;

  // Free when empty or when the current word leaves this cycle.
  assign o_free    = !r_valid || i_ready;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_partial = r_partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_partial <= 1'b0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_data    <= i_data;
      r_partial <= i_partial;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo.sv
// Serial-in/parallel-out deserializer: MSB-first symbols into words, one waiting word plus one
// filling. Define SIPO_DROP_CNT_EN to add the saturating drop_cnt_o counter.
module sipo
  import sipo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid_i,
  input  logic [SYM_W-1:0]  sym_data_i,
  input  logic              flush_i,
  input  logic              word_ready_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_data_o,
  output logic              word_partial_o,
  output logic              overflow_o,
`ifdef SIPO_DROP_CNT_EN
  output logic [7:0]        drop_cnt_o,
`endif
  input  logic              ovf_clr_i
);

  acc_state_e        r_state, w_state_next;
  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_full_partial;
  logic              r_ovf;

  logic              w_slot_free;
  logic [WORD_W-1:0] w_shift, w_acc_in, w_word;
  logic [CNT_W-1:0]  w_cnt_in;
  logic              w_done_full, w_done_flush, w_done, w_drop;
  logic              w_load, w_load_partial;
  logic [WORD_W-1:0] w_load_data;

  assign w_shift  = {r_acc[WORD_W-SYM_W-1:0], sym_data_i};
  assign w_acc_in = sym_valid_i ? w_shift : r_acc;
  assign w_cnt_in = sym_valid_i ? r_cnt + CNT_W'(1) : r_cnt;

  // A flush landing on the last symbol is just a normal full word.
  assign w_done_full  = (r_state == ACCUM) && sym_valid_i &&
                        (r_cnt == CNT_W'(SYMS_PER_WORD - 1));
  assign w_done_flush = (r_state == ACCUM) && flush_i && !w_done_full && (w_cnt_in != '0);
  assign w_done       = w_done_full || w_done_flush;
  assign w_word       = w_done_full ? w_shift : left_align(w_acc_in, w_cnt_in);
  assign w_drop       = (r_state == FULL) && sym_valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_done && !w_slot_free) w_state_next = FULL;
      FULL:    if (w_slot_free) w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_comb begin
    w_load         = 1'b0;
    w_load_data    = r_acc;
    w_load_partial = r_full_partial;
    case (r_state)
      ACCUM: begin
        if (w_done && w_slot_free) begin
          w_load         = 1'b1;
          w_load_data    = w_word;
          w_load_partial = w_done_flush;
        end
      end
      FULL:    w_load = w_slot_free;
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_full_partial <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_done) begin
            r_acc          <= w_slot_free ? '0 : w_word;
            r_cnt          <= '0;
            r_full_partial <= w_done_flush;
          end else if (sym_valid_i) begin
            r_acc <= w_shift;
            r_cnt <= w_cnt_in;
          end
        end
        FULL: begin
          if (w_slot_free) begin
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        default: begin
          r_acc <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Sticky; a drop in the clear cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (ovf_clr_i) r_ovf <= 1'b0;
  end

  assign overflow_o = r_ovf;

`ifdef SIPO_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_drop_cnt <= '0;
    else if (ovf_clr_i)                      r_drop_cnt <= {7'd0, w_drop};
    else if (w_drop && r_drop_cnt != 8'hFF)  r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_cnt_o = r_drop_cnt;
`endif

  sipo_out_slot u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_data    (w_load_data),
    .i_partial (w_load_partial),
    .i_ready   (word_ready_i),
    .o_free    (w_slot_free),
    .o_valid   (word_valid_o),
    .o_data    (word_data_o),
    .o_partial (word_partial_o)
  );

endmodule

// File: tb/tb_sipo.sv
// Directed self-checking bench for sipo; drop_cnt_o checks appear when SIPO_DROP_CNT_EN is defined.
module tb_sipo;

  logic        clk;
  logic        rst;
  logic        sym_valid_i;
  logic [1:0]  sym_data_i;
  logic        flush_i;
  logic        word_ready_i;
  logic        word_valid_o;
  logic [15:0] word_data_o;
  logic        word_partial_o;
  logic        overflow_o;
  logic        ovf_clr_i;
`ifdef SIPO_DROP_CNT_EN
  logic [7:0]  drop_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sipo dut (
    .clk            (clk),
    .rst            (rst),
    .sym_valid_i    (sym_valid_i),
    .sym_data_i     (sym_data_i),
    .flush_i        (flush_i),
    .word_ready_i   (word_ready_i),
    .word_valid_o   (word_valid_o),
    .word_data_o    (word_data_o),
    .word_partial_o (word_partial_o),
    .overflow_o     (overflow_o),
`ifdef SIPO_DROP_CNT_EN
    .drop_cnt_o     (drop_cnt_o),
`endif
    .ovf_clr_i      (ovf_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: 2 bits per cycle, most significant symbol first.
  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 8; i++) begin
      sym_valid_i = 1'b1;
      sym_data_i  = w[15-2*i -: 2];
      tick();
    end
    sym_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sym_valid_i = 1'b0; sym_data_i = 2'd0; flush_i = 1'b0;
    word_ready_i = 1'b1; ovf_clr_i = 1'b0;
    tick(); tick();
    n_checks++; if (word_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", word_valid_o); else n_pass++;
    n_checks++; if (word_data_o !== 16'h0) $display("FAIL reset_data: got %h want 0000", word_data_o); else n_pass++;
    n_checks++; if (word_partial_o !== 1'b0) $display("FAIL reset_partial: got %b want 0", word_partial_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_o); else n_pass++;
`ifdef SIPO_DROP_CNT_EN
    n_checks++; if (drop_cnt_o !== 8'd0) $display("FAIL reset_dropcnt: got %0d want 0", drop_cnt_o); else n_pass++;
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [1:0] syms [8];
    syms = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
    word_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sym_valid_i = 1'b1;
      sym_data_i  = syms[i];
      tick();
      if (i < 7) begin
        n_checks++; if (word_valid_o !== 1'b0) $display("FAIL basic_early_valid[%0d]: got %b want 0", i, word_valid_o); else n_pass++;
      end
    end
    sym_valid_i = 1'b0;
    n_checks++; if (word_valid_o !== 1'b1) $display("FAIL basic_valid: got %b want 1", word_valid_o); else n_pass++;
    n_checks++; if (word_data_o !== 16'hC9C9) $display("FAIL basic_data: got %h want c9c9", word_data_o); else n_pass++;
    n_checks++; if (word_partial_o !== 1'b0) $display("FAIL basic_partial: got %b want 0", word_partial_o); else n_pass++;
    tick();
    n_checks++; if (word_valid_o !== 1'b0) $display("FAIL basic_one_cycle: got %b want 0", word_valid_o); else n_pass++;
  endtask

  task automatic test_loopback();
    logic [15:0] pats [3];
    pats = '{16'hA5F0, 16'h0000, 16'hFFFF};
    word_ready_i = 1'b1;
    for (int p = 0; p < 3; p++) begin
      send_word(pats[p]);
      n_checks++; if (word_valid_o !== 1'b1) $display("FAIL loop_valid[%0d]: got %b want 1", p, word_valid_o); else n_pass++;
      n_checks++; if (word_data_o !== pats[p]) $display("FAIL loop_data[%0d]: got %h want %h", p, word_data_o, pats[p]); else n_pass++;
      n_checks++; if (overflow_o !== 1'b0) $display("FAIL loop_ovf[%0d]: got %b want 0", p, overflow_o); else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush();
    logic [1:0] syms [3];
    syms = '{2'd1, 2'd2, 2'd3};
    word_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sym_valid_i = 1'b1;
      sym_data_i  = syms[i];
      tick();
    end
    sym_valid_i = 1'b0;
    n_checks++; if (word_valid_o !== 1'b0) $display("FAIL flush_early: got %b want 0", word_valid_o); else n_pass++;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_checks++; if (word_valid_o !== 1'b1) $display("FAIL flush_valid: got %b want 1", word_valid_o); else n_pass++;
    n_checks++; if (word_data_o !== 16'h6C00) $display("FAIL flush_data: got %h want 6c00", word_data_o); else n_pass++;
    n_checks++; if (word_partial_o !== 1'b1) $display("FAIL flush_partial: got %b want 1", word_partial_o); else n_pass++;
    send_word(16'h1234);
    n_checks++; if (word_data_o !== 16'h1234) $display("FAIL flush_next_data: got %h want 1234", word_data_o); else n_pass++;
    n_checks++; if (word_partial_o !== 1'b0) $display("FAIL flush_next_partial: got %b want 0", word_partial_o); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    word_ready_i = 1'b0;
    send_word(16'h1234);
    send_word(16'h5678);
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL bp_ovf_early: got %b want 0", overflow_o); else n_pass++;
    send_word(16'h9ABC);
    n_checks++; if (word_valid_o !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", word_valid_o); else n_pass++;
    n_checks++; if (word_data_o !== 16'h1234) $display("FAIL bp_hold_data: got %h want 1234", word_data_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL bp_ovf: got %b want 1", overflow_o); else n_pass++;
`ifdef SIPO_DROP_CNT_EN
    n_checks++; if (drop_cnt_o !== 8'd8) $display("FAIL bp_dropcnt: got %0d want 8", drop_cnt_o); else n_pass++;
`endif
    word_ready_i = 1'b1;
    tick();
    n_checks++; if (word_valid_o !== 1'b1) $display("FAIL bp_second_valid: got %b want 1", word_valid_o); else n_pass++;
    n_checks++; if (word_data_o !== 16'h5678) $display("FAIL bp_second_data: got %h want 5678", word_data_o); else n_pass++;
    n_checks++; if (word_partial_o !== 1'b0) $display("FAIL bp_second_partial: got %b want 0", word_partial_o); else n_pass++;
    tick();
    n_checks++; if (word_valid_o !== 1'b0) $display("FAIL bp_drained: got %b want 0", word_valid_o); else n_pass++;
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL bp_ovf_clr: got %b want 0", overflow_o); else n_pass++;
`ifdef SIPO_DROP_CNT_EN
    n_checks++; if (drop_cnt_o !== 8'd0) $display("FAIL bp_dropcnt_clr: got %0d want 0", drop_cnt_o); else n_pass++;
`endif
  endtask

  task automatic test_simultaneous();
    logic [15:0] w;
    w = 16'hC3A5;
    word_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sym_valid_i = 1'b1;
      sym_data_i  = w[15-2*i -: 2];
      flush_i     = (i == 7);
      tick();
    end
    sym_valid_i = 1'b0;
    flush_i     = 1'b0;
    n_checks++; if (word_valid_o !== 1'b1) $display("FAIL sim_flush8_valid: got %b want 1", word_valid_o); else n_pass++;
    n_checks++; if (word_data_o !== 16'hC3A5) $display("FAIL sim_flush8_data: got %h want c3a5", word_data_o); else n_pass++;
    n_checks++; if (word_partial_o !== 1'b0) $display("FAIL sim_flush8_partial: got %b want 0", word_partial_o); else n_pass++;
    flush_i = 1'b1;
    tick();
    n_checks++; if (word_valid_o !== 1'b0) $display("FAIL sim_empty_flush0: got %b want 0", word_valid_o); else n_pass++;
    tick();
    flush_i = 1'b0;
    n_checks++; if (word_valid_o !== 1'b0) $display("FAIL sim_empty_flush1: got %b want 0", word_valid_o); else n_pass++;
    word_ready_i = 1'b0;
    send_word(16'h1111);
    send_word(16'h2222);
    sym_valid_i = 1'b1;
    sym_data_i  = 2'd0;
    tick();
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL sim_first_drop: got %b want 1", overflow_o); else n_pass++;
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i   = 1'b0;
    sym_valid_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL sim_clr_vs_drop: got %b want 1", overflow_o); else n_pass++;
`ifdef SIPO_DROP_CNT_EN
    n_checks++; if (drop_cnt_o !== 8'd1) $display("FAIL sim_clr_dropcnt: got %0d want 1", drop_cnt_o); else n_pass++;
`endif
    word_ready_i = 1'b1;
    tick();
    n_checks++; if (word_data_o !== 16'h2222) $display("FAIL sim_drain_data: got %h want 2222", word_data_o); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] w;
    w = 16'hABCD;
    word_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sym_valid_i = 1'b1;
      sym_data_i  = w[15-2*i -: 2];
      tick();
    end
    sym_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (word_valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", word_valid_o); else n_pass++;
    n_checks++; if (word_data_o !== 16'h0) $display("FAIL rstmid_data: got %h want 0000", word_data_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL rstmid_ovf: got %b want 0", overflow_o); else n_pass++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sym_valid_i = 1'b1;
      sym_data_i  = 2'd3;
      tick();
      if (i < 7) begin
        n_checks++; if (word_valid_o !== 1'b0) $display("FAIL rstmid_residue[%0d]: got %b want 0", i, word_valid_o); else n_pass++;
      end
    end
    sym_valid_i = 1'b0;
    n_checks++; if (word_valid_o !== 1'b1) $display("FAIL rstmid_new_valid: got %b want 1", word_valid_o); else n_pass++;
    n_checks++; if (word_data_o !== 16'hFFFF) $display("FAIL rstmid_new_data: got %h want ffff", word_data_o); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_flush();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
